// File: rtl/cfg_pos_gen_seq.sv
// Start-position generator for the address-channel cluster array.
// A start request launches a raster walk over a (row_max+1) x (col_max+1)
// grid, writing one slot per clock.
// Handshake: an accepted start_i (IDLE, not broadcast) raises busy_o on the
// next cycle. done_o pulses for exactly one cycle after the last slot is
// written. abort_i ends a walk silently.
module cfg_pos_gen_seq #(
    parameter int NUM_CLUSTER = 8,
    parameter int ROW_W       = 16,
    parameter int COL_W       = 14,
    parameter int CNT_W       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_broadcast_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic                         cfg_row_first_i,
    input  logic [CNT_W-1:0]             cfg_cluster_num_i,
    input  logic [ROW_W-1:0]             cfg_row_max_i,
    input  logic [COL_W-1:0]             cfg_col_max_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [NUM_CLUSTER-1:0]       pos_vld_o,
    output logic [NUM_CLUSTER*ROW_W-1:0] pos_row_o,
    output logic [NUM_CLUSTER*COL_W-1:0] pos_col_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] NC_CNT = CNT_W'(NUM_CLUSTER);

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic                       r_row_first;
    logic [ROW_W-1:0]           r_row_max;
    logic [COL_W-1:0]           r_col_max;
    logic [CNT_W-1:0]           r_n;
    logic [CNT_W-1:0]           r_cnt;
    logic [ROW_W-1:0]           r_row;
    logic [COL_W-1:0]           r_col;
    logic                       r_err;
    logic [NUM_CLUSTER-1:0]     r_vld;
    logic [NUM_CLUSTER*ROW_W-1:0] r_pos_row;
    logic [NUM_CLUSTER*COL_W-1:0] r_pos_col;

    logic                       w_accept;
    logic [CNT_W-1:0]           w_n_cfg;
    logic                       w_write;
    logic                       w_last_slot;
    logic                       w_at_last;
    logic [ROW_W-1:0]           w_row_nxt;
    logic [COL_W-1:0]           w_col_nxt;

    assign w_accept    = start_i & ~cfg_broadcast_i & (r_state == S_IDLE);
    // Requests beyond the number of physical slots are clamped.
    assign w_n_cfg     = (cfg_cluster_num_i > NC_CNT) ? NC_CNT : cfg_cluster_num_i;
    // Abort takes priority over a slot write on the same edge.
    assign w_write     = (r_state == S_CALC) & ~abort_i;
    assign w_last_slot = ((r_cnt + CNT_W'(1)) == r_n);
    assign w_at_last   = (r_row == r_row_max) & (r_col == r_col_max);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an empty request goes straight to DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_n_cfg == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_slot) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (r_state)
            S_CALC:  busy_o = 1'b1;
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    // Raster advance; the last cell of the grid wraps back to the origin
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (w_at_last) begin
            w_row_nxt = '0;
            w_col_nxt = '0;
        end else if (r_row_first) begin
            if (r_col == r_col_max) begin
                w_col_nxt = '0;
                w_row_nxt = r_row + 1'b1;
            end else begin
                w_col_nxt = r_col + 1'b1;
            end
        end else begin
            if (r_row == r_row_max) begin
                w_row_nxt = '0;
                w_col_nxt = r_col + 1'b1;
            end else begin
                w_row_nxt = r_row + 1'b1;
            end
        end
    end

    // Walk datapath: config latch on accept, one slot write per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_first <= 1'b0;
            r_row_max   <= '0;
            r_col_max   <= '0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_err       <= 1'b0;
            r_vld       <= '0;
            r_pos_row   <= '0;
            r_pos_col   <= '0;
        end else if (w_accept) begin
            r_row_first <= cfg_row_first_i;
            r_row_max   <= cfg_row_max_i;
            r_col_max   <= cfg_col_max_i;
            r_n         <= w_n_cfg;
            r_cnt       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_err       <= 1'b0;
            r_vld       <= '0;
        end else if (w_write) begin
            for (int k = 0; k < NUM_CLUSTER; k++) begin
                if (r_cnt == CNT_W'(k)) begin
                    r_pos_row[k*ROW_W +: ROW_W] <= r_row;
                    r_pos_col[k*COL_W +: COL_W] <= r_col;
                    r_vld[k]                    <= 1'b1;
                end
            end
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
            r_cnt <= r_cnt + 1'b1;
            // Wrapping with slots still to place means duplicates follow.
            if (w_at_last && !w_last_slot) begin
                r_err <= 1'b1;
            end
        end else if ((r_state == S_CALC) && abort_i) begin
            // Slot coordinates are kept; only their valid bits drop.
            r_vld <= '0;
        end
    end

    assign err_o     = r_err;
    assign pos_vld_o = r_vld;
    assign pos_row_o = r_pos_row;
    assign pos_col_o = r_pos_col;

endmodule

// File: tb/tb_cfg_pos_gen_seq.sv
// Testbench for cfg_pos_gen_seq: directed vector table, hand-written
// corner sequences and randomized walks against a grid-arithmetic model.
module tb_cfg_pos_gen_seq;

    localparam int NC = 8;
    localparam int RW = 16;
    localparam int CW = 14;
    localparam int NW = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_broadcast_i = 1'b0;
    logic               start_i = 1'b0;
    logic               abort_i = 1'b0;
    logic               cfg_row_first_i = 1'b0;
    logic [NW-1:0]      cfg_cluster_num_i = '0;
    logic [RW-1:0]      cfg_row_max_i = '0;
    logic [CW-1:0]      cfg_col_max_i = '0;
    logic               busy_o;
    logic               done_o;
    logic               err_o;
    logic [NC-1:0]      pos_vld_o;
    logic [NC*RW-1:0]   pos_row_o;
    logic [NC*CW-1:0]   pos_col_o;

    cfg_pos_gen_seq #(
        .NUM_CLUSTER (NC),
        .ROW_W       (RW),
        .COL_W       (CW),
        .CNT_W       (NW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_broadcast_i   (cfg_broadcast_i),
        .start_i           (start_i),
        .abort_i           (abort_i),
        .cfg_row_first_i   (cfg_row_first_i),
        .cfg_cluster_num_i (cfg_cluster_num_i),
        .cfg_row_max_i     (cfg_row_max_i),
        .cfg_col_max_i     (cfg_col_max_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .pos_vld_o         (pos_vld_o),
        .pos_row_o         (pos_row_o),
        .pos_col_o         (pos_col_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            failures = 0;
    logic [RW-1:0] m_row [NC];
    logic [CW-1:0] m_col [NC];
    logic [NC-1:0] m_vld = '0;
    logic          m_err = 1'b0;

    typedef struct {
        logic          rf;
        int            num;
        int            rmax;
        int            cmax;
        logic [NC-1:0] vld;
        logic          err;
        int            er [NC];
        int            ec [NC];
    } vec_t;

    vec_t tbl [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Compare every slot, the valid mask and err against the model.
    task automatic check_slots(input string tag);
        chk({tag, "_vld"}, 64'(pos_vld_o), 64'(m_vld));
        chk({tag, "_err"}, 64'(err_o), 64'(m_err));
        for (int k = 0; k < NC; k++) begin
            chk($sformatf("%s_row%0d", tag, k), 64'(pos_row_o[k*RW +: RW]), 64'(m_row[k]));
            chk($sformatf("%s_col%0d", tag, k), 64'(pos_col_o[k*CW +: CW]), 64'(m_col[k]));
        end
    endtask

    // Drive one walk and check the handshake cycle by cycle.
    // abort_at = a > 0 raises abort_i at edge E_a; poke re-pulses start_i at E2.
    task automatic run_walk(input logic rf, input int num, input int rmax, input int cmax,
                            input int abort_at, input logic poke, input string tag);
        int     n;
        int     w;
        int     last_c;
        longint rr;
        longint cc;
        longint rc;
        longint lin;
        logic   exp_busy;
        logic   exp_done;
        logic   exp_err;
        logic [NC-1:0] exp_vld;

        n      = (num > NC) ? NC : num;
        w      = (abort_at > 0) ? abort_at - 1 : n;
        last_c = (abort_at > 0) ? abort_at + 1 : n + 1;
        rr     = longint'(rmax) + 1;
        cc     = longint'(cmax) + 1;
        rc     = rr * cc;

        @(negedge clk);
        cfg_broadcast_i   = 1'b0;
        cfg_row_first_i   = rf;
        cfg_cluster_num_i = NW'(num);
        cfg_row_max_i     = RW'(rmax);
        cfg_col_max_i     = CW'(cmax);
        start_i           = 1'b1;

        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk);
            @(negedge clk);
            start_i = 1'b0;
            if (c == 0) begin
                cfg_row_first_i   = 1'($urandom);
                cfg_cluster_num_i = NW'($urandom);
                cfg_row_max_i     = RW'($urandom);
                cfg_col_max_i     = CW'($urandom);
            end
            if (poke && c == 1) start_i = 1'b1;

            exp_busy = (abort_at > 0) ? (c < abort_at) : (c < n);
            exp_done = (abort_at == 0) && (c == n);
            exp_err  = (n > 0) && (rc <= longint'(min2(c, min2(w, n - 1))));
            if (abort_at > 0 && c >= abort_at) exp_vld = '0;
            else exp_vld = NC'((1 << min2(c, w)) - 1);

            chk($sformatf("%s_busy_c%0d", tag, c), 64'(busy_o), 64'(exp_busy));
            chk($sformatf("%s_done_c%0d", tag, c), 64'(done_o), 64'(exp_done));
            chk($sformatf("%s_err_c%0d", tag, c), 64'(err_o), 64'(exp_err));
            chk($sformatf("%s_vld_c%0d", tag, c), 64'(pos_vld_o), 64'(exp_vld));

            abort_i = (abort_at > 0 && c == abort_at - 1);
        end
        abort_i = 1'b0;

        // Model: slot k sits at linear raster index k mod (grid size).
        for (int k = 0; k < w; k++) begin
            lin = longint'(k) % rc;
            if (rf) begin
                m_row[k] = RW'(lin / cc);
                m_col[k] = CW'(lin % cc);
            end else begin
                m_col[k] = CW'(lin / rr);
                m_row[k] = RW'(lin % rr);
            end
        end
        m_vld = (abort_at > 0) ? '0 : NC'((1 << n) - 1);
        m_err = (n > 0) && (rc <= longint'(min2(w, n - 1)));
        check_slots(tag);
    endtask

    task automatic set_tbl(input int i, input logic rf, input int num, input int rmax,
                           input int cmax, input logic [NC-1:0] vld, input logic err);
        tbl[i].rf   = rf;
        tbl[i].num  = num;
        tbl[i].rmax = rmax;
        tbl[i].cmax = cmax;
        tbl[i].vld  = vld;
        tbl[i].err  = err;
        for (int k = 0; k < NC; k++) begin
            tbl[i].er[k] = 0;
            tbl[i].ec[k] = 0;
        end
    endtask

    initial begin
        int   rf;
        int   num;
        int   n;
        int   rmax;
        int   cmax;
        int   ab;
        logic pk;

        for (int k = 0; k < NC; k++) begin
            m_row[k] = '0;
            m_col[k] = '0;
        end

        // Directed vectors with hand-derived coordinates.
        set_tbl(0, 1'b1, 4, 9, 2, 8'h0F, 1'b0);
        tbl[0].er[0] = 0; tbl[0].ec[0] = 0;
        tbl[0].er[1] = 0; tbl[0].ec[1] = 1;
        tbl[0].er[2] = 0; tbl[0].ec[2] = 2;
        tbl[0].er[3] = 1; tbl[0].ec[3] = 0;
        set_tbl(1, 1'b0, 3, 1, 5, 8'h07, 1'b0);
        tbl[1].er[0] = 0; tbl[1].ec[0] = 0;
        tbl[1].er[1] = 1; tbl[1].ec[1] = 0;
        tbl[1].er[2] = 0; tbl[1].ec[2] = 1;
        set_tbl(2, 1'b1, 5, 1, 1, 8'h1F, 1'b1);
        tbl[2].er[0] = 0; tbl[2].ec[0] = 0;
        tbl[2].er[1] = 0; tbl[2].ec[1] = 1;
        tbl[2].er[2] = 1; tbl[2].ec[2] = 0;
        tbl[2].er[3] = 1; tbl[2].ec[3] = 1;
        tbl[2].er[4] = 0; tbl[2].ec[4] = 0;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err",  64'(err_o),  64'd0);
        chk("rst_vld",  64'(pos_vld_o), 64'd0);
        chk("rst_row",  64'(|pos_row_o), 64'd0);
        chk("rst_col",  64'(|pos_col_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 3; i++) begin
            run_walk(tbl[i].rf, tbl[i].num, tbl[i].rmax, tbl[i].cmax, 0, 1'b0,
                     $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_vld", i), 64'(pos_vld_o), 64'(tbl[i].vld));
            chk($sformatf("tbl%0d_err", i), 64'(err_o), 64'(tbl[i].err));
            for (int k = 0; k < tbl[i].num; k++) begin
                chk($sformatf("tbl%0d_r%0d", i, k), 64'(pos_row_o[k*RW +: RW]), 64'(tbl[i].er[k]));
                chk($sformatf("tbl%0d_c%0d", i, k), 64'(pos_col_o[k*CW +: CW]), 64'(tbl[i].ec[k]));
            end
        end

        // ---------------- broadcast blocks start ----------------
        @(negedge clk);
        cfg_broadcast_i   = 1'b1;
        cfg_cluster_num_i = NW'(3);
        start_i           = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bcast_busy", 64'(busy_o), 64'd0);
            chk("bcast_done", 64'(done_o), 64'd0);
            @(negedge clk);
        end
        check_slots("bcast");
        cfg_broadcast_i = 1'b0;

        // ---------------- start while busy, abort, recovery ----------------
        run_walk(1'b1, 6, 3, 3, 0, 1'b1, "poke");
        run_walk(1'b0, 8, 7, 7, 3, 1'b0, "abort");
        run_walk(1'b1, 8, 2, 4, 0, 1'b0, "after_abort");

        // ---------------- empty and oversized requests ----------------
        run_walk(1'b1, 0, 5, 5, 0, 1'b0, "n0");
        run_walk(1'b0, 15, 2, 1, 0, 1'b0, "n15");
        run_walk(1'b1, 8, 65535, 16383, 0, 1'b0, "allones");

        // ---------------- reset mid-walk ----------------
        @(negedge clk);
        cfg_row_first_i   = 1'b1;
        cfg_cluster_num_i = NW'(8);
        cfg_row_max_i     = RW'(4);
        cfg_col_max_i     = CW'(4);
        start_i           = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        chk("midrst_err",  64'(err_o),  64'd0);
        chk("midrst_vld",  64'(pos_vld_o), 64'd0);
        chk("midrst_row",  64'(|pos_row_o), 64'd0);
        chk("midrst_col",  64'(|pos_col_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NC; k++) begin
            m_row[k] = '0;
            m_col[k] = '0;
        end
        m_vld = '0;
        m_err = 1'b0;
        @(negedge clk);
        chk("midrst_idle_busy", 64'(busy_o), 64'd0);

        // ---------------- randomized walks ----------------
        for (int i = 0; i < 30; i++) begin
            rf  = $urandom_range(0, 1);
            num = $urandom_range(0, 15);
            n   = (num > NC) ? NC : num;
            case ($urandom_range(0, 3))
                0:       rmax = $urandom_range(0, 3);
                1:       rmax = 65535;
                2:       rmax = $urandom_range(0, 65535);
                default: rmax = 0;
            endcase
            case ($urandom_range(0, 3))
                0:       cmax = $urandom_range(0, 3);
                1:       cmax = 16383;
                2:       cmax = $urandom_range(0, 16383);
                default: cmax = 0;
            endcase
            ab = (n >= 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            pk = (n >= 2) && (ab == 0 || ab >= 2) && ($urandom_range(0, 1) == 1);
            run_walk(rf[0], num, rmax, cmax, ab, pk, $sformatf("rnd%0d", i));
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
